// File: rtl/ram_pkg.sv
// Shared constants and FSM state type for the clearable dual-port RAM.
package ram_pkg;

  localparam int DATA_W_DEF = 3;
  localparam int ADDR_W_DEF = 5;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/ram_core.sv
// Storage array: one write port and one registered read port, array itself never reset.
// Build option RAM_BYPASS_EN selects write-first on a same-address read/write; default is read-first.
import ram_pkg::*;

module ram_core #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              rd_zero,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  // rd_zero covers the sweep: every word is (or is about to be) zero, so the
  // read register loads 0 rather than a stale value of the word being cleared.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdata <= '0;
    end else if (rd_zero) begin
      rdata <= '0;
`ifdef RAM_BYPASS_EN
    end else if (we && (waddr == raddr)) begin
      rdata <= wdata;
`endif
    end else begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/dual_port_ram_clr.sv
// Dual-port RAM with a hardware clear sweep, run on request and after every reset.
// Build option RAM_BYPASS_EN (see ram_core) selects write-first read-during-write.
import ram_pkg::*;

// state | meaning
// IDLE  | normal read/write access; waits for clr_req or post-reset clear
// CLEAR | counter writes 0 to one address per cycle, 0..DEPTH-1
module dual_port_ram_clr #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wren,
  input  logic [ADDR_W-1:0] wraddr,
  input  logic [DATA_W-1:0] data,
  input  logic [ADDR_W-1:0] rdaddr,
  output logic [DATA_W-1:0] q,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic              boot_clr;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] core_q;

  // boot_clr makes the first edge after reset start a sweep without a request.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      clr_cnt  <= '0;
      boot_clr <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (clr_req || boot_clr) begin
            state    <= CLEAR;
            clr_cnt  <= '0;
            boot_clr <= 1'b0;
          end
        end
        CLEAR: begin
          if (clr_cnt == LAST_ADDR) begin
            state   <= IDLE;
            clr_cnt <= '0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          clr_cnt <= '0;
        end
      endcase
    end
  end

  assign busy     = (state == CLEAR);
  assign clr_done = busy && (clr_cnt == LAST_ADDR);

  always_comb begin
    mem_we    = wren;
    mem_waddr = wraddr;
    mem_wdata = data;
    if (busy) begin
      mem_we    = 1'b1;
      mem_waddr = clr_cnt;
      mem_wdata = '0;
    end
  end

  ram_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_core (
    .clock   (clock),
    .reset   (reset),
    .we      (mem_we),
    .waddr   (mem_waddr),
    .wdata   (mem_wdata),
    .raddr   (rdaddr),
    .rd_zero (busy),
    .rdata   (core_q)
  );

  // Register still holds the last IDLE read on the first sweep cycle.
  assign q = busy ? '0 : core_q;

endmodule

// File: tb/tb_dual_port_ram_clr.sv
// Directed bench for dual_port_ram_clr: default 3x32 instance plus an 8x8 instance.
module tb_dual_port_ram_clr;

  logic       clock = 1'b0;
  logic       reset = 1'b1;

  logic       wren = 1'b0;
  logic [4:0] wraddr = '0;
  logic [2:0] data = '0;
  logic [4:0] rdaddr = '0;
  logic       clr_req = 1'b0;
  logic [2:0] q;
  logic       busy;
  logic       clr_done;

  logic       wren2 = 1'b0;
  logic [2:0] wraddr2 = '0;
  logic [7:0] data2 = '0;
  logic [2:0] rdaddr2 = '0;
  logic       clr_req2 = 1'b0;
  logic [7:0] q2;
  logic       busy2;
  logic       clr_done2;

  int n_checks = 0;
  int n_errors = 0;

`ifdef RAM_BYPASS_EN
  localparam logic [2:0] EXP_RDW = 3'd5;
`else
  localparam logic [2:0] EXP_RDW = 3'd0;
`endif

  always #5 clock = ~clock;

  dual_port_ram_clr u_dut (
    .clock    (clock),
    .reset    (reset),
    .wren     (wren),
    .wraddr   (wraddr),
    .data     (data),
    .rdaddr   (rdaddr),
    .q        (q),
    .clr_req  (clr_req),
    .busy     (busy),
    .clr_done (clr_done)
  );

  dual_port_ram_clr #(
    .DATA_W (8),
    .ADDR_W (3)
  ) u_dut8 (
    .clock    (clock),
    .reset    (reset),
    .wren     (wren2),
    .wraddr   (wraddr2),
    .data     (data2),
    .rdaddr   (rdaddr2),
    .q        (q2),
    .clr_req  (clr_req2),
    .busy     (busy2),
    .clr_done (clr_done2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // mode 1: try a write to address 2 mid-sweep; mode >= 1: clr_req pulse at cycle 10
  task automatic sweep(input int mode, output int nb, output int done_at,
                       output int nd, output int qnz, output int nb2);
    nb = 0; done_at = 0; nd = 0; qnz = 0; nb2 = 0;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clock);
      if (busy) nb++;
      if (clr_done) begin
        nd++;
        done_at = k;
      end
      if (busy && (q != 3'd0)) qnz++;
      if (busy2) nb2++;
      clr_req = 1'b0;
      if (mode == 1 && k == 5) begin
        wren = 1'b1; wraddr = 5'd2; data = 3'd6; rdaddr = 5'd2;
      end
      if (mode == 1 && k == 6) wren = 1'b0;
      if (mode >= 1 && k == 10) clr_req = 1'b1;
    end
  endtask

  task automatic read_all_zero(input string tag);
    for (int i = 0; i <= 32; i++) begin
      @(negedge clock);
      if (i > 0) chk($sformatf("%s_rd%0d", tag, i - 1), {29'd0, q}, 32'd0);
      rdaddr = 5'(i);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int nb, da, nd, qnz, nb2;

    repeat (3) @(negedge clock);
    chk("rst_q", {29'd0, q}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, clr_done}, 32'd0);
    chk("rst_busy8", {31'd0, busy2}, 32'd0);

    reset = 1'b0;
    sweep(0, nb, da, nd, qnz, nb2);
    chk("boot_busy_cycles", nb, 32);
    chk("boot_done_at", da, 32);
    chk("boot_done_pulses", nd, 1);
    chk("boot_q_while_busy", qnz, 0);
    chk("p8_boot_busy_cycles", nb2, 8);
    read_all_zero("boot");

    // same-address read during write
    @(negedge clock);
    wren = 1'b1; wraddr = 5'd3; data = 3'd5; rdaddr = 5'd3;
    @(negedge clock);
    wren = 1'b0;
    chk("rdw_same_addr", {29'd0, q}, {29'd0, EXP_RDW});
    @(negedge clock);
    chk("rdw_next_read", {29'd0, q}, 32'd5);

    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      wren = 1'b1; wraddr = 5'(i); data = 3'(7 - i);
    end
    @(negedge clock);
    wren = 1'b0;
    for (int i = 0; i <= 8; i++) begin
      @(negedge clock);
      if (i > 0) chk($sformatf("wr_rd%0d", i - 1), {29'd0, q}, 32'(8 - i));
      rdaddr = 5'(i);
    end

    @(negedge clock);
    wren2 = 1'b1; wraddr2 = 3'd7; data2 = 8'hA5; rdaddr2 = 3'd7;
    @(negedge clock);
    wren2 = 1'b0;
    @(negedge clock);
    chk("p8_rd7", {24'd0, q2}, 32'hA5);

    // requested clear with a dropped write inside the sweep
    rdaddr = 5'd4;
    @(negedge clock);
    chk("pre_clear_q", {29'd0, q}, 32'd3);
    clr_req = 1'b1;
    sweep(1, nb, da, nd, qnz, nb2);
    chk("clr_busy_cycles", nb, 32);
    chk("clr_done_at", da, 32);
    chk("clr_done_pulses", nd, 1);
    chk("clr_q_while_busy", qnz, 0);
    chk("p8_idle_busy", nb2, 0);
    read_all_zero("clr");

    // reset while idle with nonzero q
    @(negedge clock);
    wren = 1'b1; wraddr = 5'd1; data = 3'd5; rdaddr = 5'd1;
    @(negedge clock);
    wren = 1'b0;
    @(negedge clock);
    chk("idle_q_before_rst", {29'd0, q}, 32'd5);
    reset = 1'b1;
    #1;
    chk("idle_rst_q", {29'd0, q}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    sweep(0, nb, da, nd, qnz, nb2);
    chk("rst2_busy_cycles", nb, 32);

    // reset during sweep cycle 10
    @(negedge clock);
    clr_req = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      clr_req = 1'b0;
    end
    chk("mid_busy_before_rst", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, clr_done}, 32'd0);
    chk("mid_rst_q", {29'd0, q}, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    sweep(2, nb, da, nd, qnz, nb2);
    chk("mid_busy_cycles", nb, 32);
    chk("mid_done_at", da, 32);
    chk("mid_done_pulses", nd, 1);
    chk("p8_mid_busy_cycles", nb2, 8);
    read_all_zero("mid");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dual_port_ram_clr.md
DUAL_PORT_RAM_CLR -- requirements
Module: dual_port_ram_clr

Interface
REQ-001 Parameter DATA_W, default 3, data word width in bits (1..32).
REQ-002 Parameter ADDR_W, default 5, address width; DEPTH = 2**ADDR_W words.
REQ-003 clock  input  1  single clock for all logic; all flops update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 wren  input  1  write enable for the write port.
REQ-006 wraddr  input  ADDR_W  write address.
REQ-007 data  input  DATA_W  write data.
REQ-008 rdaddr  input  ADDR_W  read address.
REQ-009 q  output  DATA_W  registered read data.
REQ-010 clr_req  input  1  single-cycle pulse requesting a full-array clear.
REQ-011 busy  output  1  high while a clear sweep is in progress.
REQ-012 clr_done  output  1  one-cycle pulse on the final cycle of a sweep.

Function
REQ-013 Write: when busy=0 and wren=1 at a rising edge, mem[wraddr] SHALL take data.
REQ-014 Read: q SHALL equal mem[rdaddr] as sampled at the previous rising edge (1-cycle latency), with the read port usable on every cycle, independent of the write port.
REQ-015 FSM states: IDLE and CLEAR.
- IDLE -> CLEAR on clr_req=1.
- CLEAR -> IDLE after address DEPTH-1 is written.
REQ-016 In CLEAR, an internal counter SHALL write 0 to addresses 0,1,...,DEPTH-1, one per cycle; a sweep SHALL take exactly DEPTH cycles.
REQ-017 busy SHALL be high for exactly the DEPTH cycles the FSM spends in CLEAR.
REQ-018 clr_done SHALL pulse in the cycle address DEPTH-1 is cleared, coincident with the final busy cycle.
REQ-019 While busy=1, wren SHALL be ignored (write dropped, no queueing), and q SHALL be 0.
REQ-020 clr_req while busy=1 SHALL be ignored; the sweep does not restart.
REQ-021 clr_req and wren in the same IDLE cycle: the write SHALL complete, then the sweep SHALL start next cycle.
REQ-022 The counter SHALL not wrap: after DEPTH-1 it returns to 0 with the FSM in IDLE.
REQ-023 Read-during-write to the same address: see REQ-027/028.

Reset
REQ-024 Asserting reset SHALL immediately force q=0, busy=0, clr_done=0, counter=0, FSM=IDLE; memory contents are not reset directly.
REQ-025 On the first rising edge after reset deasserts, the FSM SHALL enter CLEAR automatically, so the array is zeroed before first use.
REQ-026 Reset asserted mid-sweep SHALL abort the sweep; a fresh full sweep from address 0 follows deassertion.

Configuration
REQ-027 With RAM_BYPASS_EN defined: for wren=1, busy=0 and rdaddr==wraddr, the next q SHALL be the new data (write-first).
REQ-028 Without RAM_BYPASS_EN: the next q SHALL be the old contents (read-first); the macro SHALL have no other effect.

Structure
REQ-029 Package ram_pkg SHALL hold the FSM state enum (IDLE, CLEAR) and the default DATA_W/ADDR_W constants.
REQ-030 Storage SHALL be a sub-module ram_core: one write port and one registered read port, with no reset on the array. The FSM, counter and write mux stay in the top level.

Verification
REQ-031 Reset then release -> busy high for exactly 32 cycles, clr_done on the 32nd cycle, and every address then reads 0.
REQ-032 IDLE, write addresses 0..7 with data 7-i, then read 0..7 -> q = 7,6,...,0, each one cycle after its rdaddr.
REQ-033 Write 5 to address 3 while reading address 3 in the same cycle -> next q=5 with RAM_BYPASS_EN, old value (0) without it.
REQ-034 After REQ-032, pulse clr_req and assert wren to address 2 with data 6 mid-sweep -> write dropped, q=0 while busy, and address 2 reads 0 after the sweep.
REQ-035 Assert reset at sweep cycle 10 -> outputs zero immediately, then a full 32-cycle sweep after release; clr_req during the sweep does not extend busy.
REQ-036 Parameters DATA_W=8, ADDR_W=3 -> sweep lasts 8 cycles, and write/read of 0xA5 at address 7 returns 0xA5.
